// File: rtl/cpu_clock_ctrl_pkg.sv
// Shared encodings for the CPU clock/reset sequencer: FSM states and phase landmarks.
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } cpu_state_e;

    localparam logic [1:0] PH_FIRST = 2'd0;
    localparam logic [1:0] PH_LAST  = 2'd3;
    // Phase just before processor_clock rises; leaving it counts one processor cycle.
    localparam logic [1:0] PH_RISE  = 2'd1;

endpackage

// File: rtl/cpu_clock_ctrl_reset_stretch.sv
// Stretches the released system reset into a CPU reset held for HOLD_CYCLES master edges.
module reset_stretch #(
    parameter int HOLD_CYCLES = 16,
    parameter int HOLD_W      = 8
) (
    input  logic clock,
    input  logic reset,
    output logic cpu_reset,
    output logic hold_done
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              cpu_reset_q, cpu_reset_d;

    always_comb begin
        hold_cnt_d  = hold_cnt_q;
        cpu_reset_d = cpu_reset_q;
        hold_done   = cpu_reset_q && (hold_cnt_q == HOLD_LAST);
        if (cpu_reset_q) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            if (hold_done) begin
                cpu_reset_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            hold_cnt_q  <= '0;
            cpu_reset_q <= 1'b1;
        end else begin
            hold_cnt_q  <= hold_cnt_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    assign cpu_reset = cpu_reset_q;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Clock/reset sequencer for the processor: divided clocks, stretched reset,
// run/halt/single-step debug control that always stops on a processor-period boundary.
module cpu_clock_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int HOLD_CYCLES   = 16,
    parameter int HOLD_W        = 8,
    parameter bit START_RUNNING = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    output logic             imem_clock,
    output logic             dmem_clock,
    output logic             processor_clock,
    output logic             regfile_clock,
    output logic             cpu_reset,
    output logic             halted,
    output logic             step_done,
    output logic [CNT_W-1:0] cycle_count
);

    cpu_state_e       state_q, state_d;
    logic [1:0]       ph_q, ph_d;
    logic             drain_q, drain_d;
    logic             halted_q, halted_d;
    logic             step_done_q, step_done_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic             hold_done;

    reset_stretch #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .HOLD_W      (HOLD_W)
    ) u_reset_stretch (
        .clock     (clock),
        .reset     (reset),
        .cpu_reset (cpu_reset),
        .hold_done (hold_done)
    );

    always_comb begin
        state_d       = state_q;
        ph_d          = ph_q;
        drain_d       = drain_q;
        halted_d      = halted_q;
        step_done_d   = 1'b0;
        cycle_count_d = (ph_q == PH_RISE) ? cycle_count_q + 1'b1 : cycle_count_q;

        case (state_q)
            HOLD: begin
                ph_d = PH_FIRST;
                if (hold_done) begin
                    state_d  = START_RUNNING ? RUN : HALTED;
                    halted_d = !START_RUNNING;
                end
            end
            RUN: begin
                ph_d = ph_q + 2'd1;
                if (halt_req) begin
                    drain_d = 1'b1;
                end
                // A halt seen on the last phase still lets that period finish at this edge.
                if ((ph_q == PH_LAST) && (drain_q || halt_req)) begin
                    state_d  = HALTED;
                    halted_d = 1'b1;
                    drain_d  = 1'b0;
                end
            end
            HALTED: begin
                ph_d = PH_FIRST;
                if (halt_req) begin
                    state_d = HALTED;
                end else if (step_req) begin
                    state_d  = STEP;
                    ph_d     = PH_FIRST + 2'd1;
                    halted_d = 1'b0;
                end else if (run_req) begin
                    state_d  = RUN;
                    ph_d     = PH_FIRST + 2'd1;
                    halted_d = 1'b0;
                end
            end
            STEP: begin
                ph_d = ph_q + 2'd1;
                if (ph_q == PH_LAST) begin
                    state_d     = HALTED;
                    halted_d    = 1'b1;
                    step_done_d = 1'b1;
                end
            end
            default: begin
                state_d = HOLD;
                ph_d    = PH_FIRST;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= HOLD;
            ph_q          <= PH_FIRST;
            drain_q       <= 1'b0;
            halted_q      <= 1'b0;
            step_done_q   <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ph_q          <= ph_d;
            drain_q       <= drain_d;
            halted_q      <= halted_d;
            step_done_q   <= step_done_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign imem_clock      = clock;
    assign dmem_clock      = clock;
    assign processor_clock = ph_q[1];
    assign regfile_clock   = ~ph_q[0];
    assign halted          = halted_q;
    assign step_done       = step_done_q;
    assign cycle_count     = cycle_count_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Scoreboard bench for cpu_clock_ctrl: a behavioural model predicts every cycle's outputs,
// a negedge monitor pops the predictions and compares them with the DUT.
module tb_cpu_clock_ctrl;

    localparam int HOLD_CYCLES = 4;
    localparam int CNT_W       = 4;
    localparam int WAIT_LIMIT  = 50;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             run_req = 1'b0;
    logic             halt_req = 1'b0;
    logic             step_req = 1'b0;
    logic             imem_clock, dmem_clock, processor_clock, regfile_clock;
    logic             cpu_reset, halted, step_done;
    logic [CNT_W-1:0] cycle_count;

    cpu_clock_ctrl #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .HOLD_W        (8),
        .START_RUNNING (1'b1),
        .CNT_W         (CNT_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .run_req         (run_req),
        .halt_req        (halt_req),
        .step_req        (step_req),
        .imem_clock      (imem_clock),
        .dmem_clock      (dmem_clock),
        .processor_clock (processor_clock),
        .regfile_clock   (regfile_clock),
        .cpu_reset       (cpu_reset),
        .halted          (halted),
        .step_done       (step_done),
        .cycle_count     (cycle_count)
    );

    initial forever #5 clock = ~clock;

    typedef struct packed {
        logic             imem;
        logic             dmem;
        logic             proc_clk;
        logic             reg_clk;
        logic             cpu_rst;
        logic             halted;
        logic             step_done;
        logic [CNT_W-1:0] count;
    } expect_t;

    expect_t exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: a phase 0..3 inside the processor period, a mode, and a running
    // tally of processor_clock rising edges.
    typedef enum {M_HOLDING, M_RUNNING, M_STOPPED, M_STEPPING} mode_t;
    mode_t m_mode = M_HOLDING;
    int    m_phase = 0;
    int    m_hold_edges = 0;
    int    m_rises = 0;
    bit    m_cpu_rst = 1'b1;
    bit    m_halted = 1'b0;
    bit    m_done = 1'b0;
    bit    m_drain = 1'b0;

    task automatic model_edge(input bit rst_n, input bit run, input bit halt, input bit step);
        bit was_high;
        if (!rst_n) begin
            m_mode = M_HOLDING; m_phase = 0; m_hold_edges = 0; m_rises = 0;
            m_cpu_rst = 1'b1; m_halted = 1'b0; m_done = 1'b0; m_drain = 1'b0;
            return;
        end
        was_high = (m_phase >= 2);
        m_done = 1'b0;
        case (m_mode)
            M_HOLDING: begin
                m_hold_edges++;
                if (m_hold_edges == HOLD_CYCLES) begin
                    m_cpu_rst = 1'b0;
                    m_mode    = M_RUNNING;
                end
            end
            M_RUNNING: begin
                m_drain = m_drain | halt;
                if (m_phase == 3 && m_drain) begin
                    m_mode = M_STOPPED; m_halted = 1'b1; m_drain = 1'b0; m_phase = 0;
                end else begin
                    m_phase = (m_phase + 1) % 4;
                end
            end
            M_STOPPED: begin
                if (!halt && (step || run)) begin
                    m_mode   = step ? M_STEPPING : M_RUNNING;
                    m_phase  = 1;
                    m_halted = 1'b0;
                end
            end
            M_STEPPING: begin
                if (m_phase == 3) begin
                    m_mode = M_STOPPED; m_phase = 0; m_halted = 1'b1; m_done = 1'b1;
                end else begin
                    m_phase++;
                end
            end
            default: ;
        endcase
        if (!was_high && (m_phase >= 2)) m_rises++;
    endtask

    function automatic expect_t model_out();
        expect_t e;
        e.imem      = 1'b0;
        e.dmem      = 1'b0;
        e.proc_clk  = (m_phase >= 2);
        e.reg_clk   = ((m_phase % 2) == 0);
        e.cpu_rst   = m_cpu_rst;
        e.halted    = m_halted;
        e.step_done = m_done;
        e.count     = CNT_W'(m_rises % (1 << CNT_W));
        return e;
    endfunction

    task automatic applyStimulus(input bit rst_n, input bit run, input bit halt, input bit step);
        reset    = rst_n;
        run_req  = run;
        halt_req = halt;
        step_req = step;
        @(posedge clock);
        #1;
        model_edge(rst_n, run, halt, step);
        exp_q.push_back(model_out());
    endtask

    task automatic checkOutput(input expect_t e);
        expect_t act;
        act = {imem_clock, dmem_clock, processor_clock, regfile_clock,
               cpu_reset, halted, step_done, cycle_count};
        vectors++;
        if (act !== e) begin
            miscompares++;
            $display("[TB] FAIL outputs vec %0d: got imem=%b dmem=%b pclk=%b rclk=%b rst=%b halted=%b done=%b cnt=%0d, want imem=%b dmem=%b pclk=%b rclk=%b rst=%b halted=%b done=%b cnt=%0d",
                     vectors, act.imem, act.dmem, act.proc_clk, act.reg_clk, act.cpu_rst,
                     act.halted, act.step_done, act.count, e.imem, e.dmem, e.proc_clk,
                     e.reg_clk, e.cpu_rst, e.halted, e.step_done, e.count);
        end
    endtask

    // Idle-advance until the model reaches a given mode and phase, so a request lands there.
    task automatic advance_to(input mode_t want_mode, input int want_phase);
        int n = 0;
        while (!(m_mode == want_mode && m_phase == want_phase) && n < WAIT_LIMIT) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            n++;
        end
        if (n >= WAIT_LIMIT) begin
            miscompares++;
            $display("[TB] FAIL advance_to: reached mode=%0d phase=%0d, wanted mode=%0d phase=%0d",
                     m_mode, m_phase, want_mode, want_phase);
        end
    endtask

    initial forever begin
        @(negedge clock);
        if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
    end

    initial begin
        int n;
        $display("[TB] reset held, release, hold sequence and free-running waveform");
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (20) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] halt pulse at phase 1");
        advance_to(M_RUNNING, 1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] single step from halted");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] simultaneous requests, then halt dropped");
        repeat (4) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset during a step at phase 2, then long run for counter wrap");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        advance_to(M_STEPPING, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (80) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] randomized requests");
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 99) != 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 3) == 0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(negedge clock);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
